eth_frame_tx: RTL



---
 rtl/eth_frame_tx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_frame_tx.sv
// Cut-through GbE frame transmitter: wraps the upstream 16-bit payload stream in
// /S/, preamble, MAC header, padding, FCS and /T/R/, one 8b10b-ready word per clock.
module eth_frame_tx #(
  parameter logic [47:0] DEST_MAC  = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200DCFE0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int unsigned IFG_WORDS = 6
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DATA_RDY,
  input  logic [15:0] TXD,
  input  logic        TXD_VLD,
  output logic        TXACK,
  output logic [15:0] TXDATA,
  output logic [1:0]  TXCHARISK,
  output logic        BUSY,
  output logic [15:0] FRM_CNT,
  output logic [7:0]  ERR_CNT
);

  localparam logic [12:0] MIN_PAY  = 13'd23;
  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [7:0]  IFG_LAST = 8'(IFG_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SOP, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCSL, S_FCSH, S_EOP, S_IFG
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [12:0] pay_q, pay_d;
  logic        runt_q, runt_d, runt_ev;
  logic [31:0] crc_q, crc_d;
  logic [15:0] word_d;
  logic [1:0]  k_d;

  logic [15:0] mem_q [16];
  logic [3:0]  wr_q, rd_q;
  logic [4:0]  cnt_q;
  logic        stray_q;

  logic [15:0] txdata_q;
  logic [1:0]  txk_q;
  logic        txack_q, busy_q;
  logic [15:0] frm_q;
  logic [7:0]  err_q;

  logic open, fifo_ne, avail, pop, bypass, wr_en, push, ovf, stray, err_ev;

  function automatic logic [15:0] hdr_word(input logic [2:0] i);
    logic [95:0] macs;
    int          ii;
    macs = {DEST_MAC, SRC_MAC};
    ii   = int'(i);
    if (i == 3'd6) return {ETHERTYPE[7:0], ETHERTYPE[15:8]};
    return {macs[87 - 16*ii -: 8], macs[95 - 16*ii -: 8]};
  endfunction

  // Reflected CRC-32, bit-serial, low byte first (d[0] is the first bit on the wire).
  function automatic logic [31:0] crc16(input logic [31:0] c, input logic [15:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 16; b++) r = (r[0] ^ d[b]) ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign open    = state_q inside {S_SOP, S_PRE, S_SFD, S_HDR, S_PAY};
  assign fifo_ne = (cnt_q != 5'd0);
  // A word arriving in the same cycle it is needed is forwarded straight from TXD.
  assign avail   = fifo_ne || (TXD_VLD && open);
  assign stray   = TXD_VLD && !open;
  assign wr_en   = TXD_VLD && open && !bypass;
  assign push    = wr_en && ((cnt_q != 5'd16) || pop);
  assign ovf     = wr_en && !push;
  assign err_ev  = (stray && !stray_q) || ovf || runt_ev;

  always_comb begin
    state_d = state_q;
    idx_d   = '0;
    runt_d  = runt_q;
    runt_ev = 1'b0;
    case (state_q)
      S_IDLE: if (DATA_RDY) state_d = S_SOP;
      S_SOP:  state_d = S_PRE;
      S_PRE:  if (idx_q == 8'd1) state_d = S_SFD; else idx_d = idx_q + 8'd1;
      S_SFD:  state_d = S_HDR;
      S_HDR: begin
        if (idx_q != 8'd6) idx_d = idx_q + 8'd1;
        else if (avail) state_d = S_PAY;
        else begin
          state_d = S_PAD;
          runt_d  = 1'b1;
          runt_ev = 1'b1;
        end
      end
      S_PAY, S_PAD: begin
        if (state_q == S_PAY && avail) state_d = S_PAY;
        else if (pay_q < MIN_PAY)      state_d = S_PAD;
        else                           state_d = S_FCSL;
      end
      S_FCSL: state_d = S_FCSH;
      S_FCSH: state_d = S_EOP;
      S_EOP:  state_d = S_IFG;
      S_IFG: begin
        if (idx_q == IFG_LAST) state_d = DATA_RDY ? S_SOP : S_IDLE;
        else idx_d = idx_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_SOP) runt_d = 1'b0;
  end

  always_comb begin
    word_d = 16'h50BC;
    k_d    = 2'b01;
    crc_d  = crc_q;
    pop    = 1'b0;
    bypass = 1'b0;
    pay_d  = pay_q;
    case (state_d)
      S_SOP: begin
        word_d = 16'h55FB;
        crc_d  = '1;
        pay_d  = '0;
      end
      S_PRE: begin word_d = 16'h5555; k_d = 2'b00; end
      S_SFD: begin word_d = 16'hD555; k_d = 2'b00; end
      S_HDR: begin
        word_d = hdr_word(idx_d[2:0]);
        k_d    = 2'b00;
        crc_d  = crc16(crc_q, word_d);
      end
      S_PAY, S_PAD: begin
        k_d = 2'b00;
        if (state_d == S_PAD) word_d = 16'h0000;
        else if (fifo_ne) begin
          word_d = mem_q[rd_q];
          pop    = 1'b1;
        end else begin
          word_d = TXD;
          bypass = 1'b1;
        end
        crc_d = crc16(crc_q, word_d);
        pay_d = (pay_q == '1) ? pay_q : pay_q + 13'd1;
      end
      // A runt is flagged downstream by sending the CRC un-inverted.
      S_FCSL: begin word_d = runt_q ? crc_q[15:0]  : ~crc_q[15:0];  k_d = 2'b00; end
      S_FCSH: begin word_d = runt_q ? crc_q[31:16] : ~crc_q[31:16]; k_d = 2'b00; end
      S_EOP:  begin word_d = 16'hF7FD; k_d = 2'b11; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= TXD;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      pay_q    <= '0;
      runt_q   <= 1'b0;
      crc_q    <= '1;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      stray_q  <= 1'b0;
      txdata_q <= 16'h50BC;
      txk_q    <= 2'b01;
      txack_q  <= 1'b0;
      busy_q   <= 1'b0;
      frm_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pay_q    <= pay_d;
      runt_q   <= runt_d;
      crc_q    <= crc_d;
      stray_q  <= stray;
      if (push) wr_q <= wr_q + 4'd1;
      if (pop)  rd_q <= rd_q + 4'd1;
      cnt_q    <= cnt_q + {4'b0, push} - {4'b0, pop};
      txdata_q <= word_d;
      txk_q    <= k_d;
      txack_q  <= (state_d == S_SOP);
      busy_q   <= (state_d != S_IDLE);
      if (state_d == S_EOP) frm_q <= frm_q + 16'd1;
      if (err_ev && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign TXDATA    = txdata_q;
  assign TXCHARISK = txk_q;
  assign TXACK     = txack_q;
  assign BUSY      = busy_q;
  assign FRM_CNT   = frm_q;
  assign ERR_CNT   = err_q;

endmodule
